fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the controller/datapath; produces the instruction word and its PC for the execute side.
- Owns the fetch PC and issues requests to instruction memory with a ready/valid handshake that tolerates variable latency.
- Buffers returned instructions in a small in-order prefetch queue.
- Accepts a taken-branch redirect (PCSrc + target), flushes the queue and discards any responses still in flight.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC, issues word requests to instruction memory over a
// ready/valid handshake with variable, in-order response latency, and buffers
// returned words in a small in-order prefetch queue. A redirect (PCSrc) moves
// the fetch PC, empties the queue and discards every response still in flight.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr  request valid and word-aligned fetch address
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   in-order response strobe and instruction word
//   PCSrc/pc_target     redirect strobe and target address
//   stall               downstream cannot consume this cycle
//   Instr/instr_pc      head-of-queue instruction and its PC
//   instr_valid         Instr/instr_pc are valid
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 26,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  pc_target,
    input  logic               stall,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CSW = CW + 1;

    logic [ADDR_W-1:0]  fetch_pc;

    // prefetch queue of returned instructions
    logic [INSTR_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0]  q_pc   [DEPTH];
    logic [PW-1:0]      q_head, q_tail;
    logic [CW-1:0]      q_cnt;

    // addresses of every request in flight, oldest at r_head
    logic [ADDR_W-1:0]  r_pc [DEPTH];
    logic [PW-1:0]      r_head, r_tail;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      drop_cnt;

    logic               fire, resp, push, pop;
    logic [CSW-1:0]     credit_used;

    // request issue, response acceptance and pop decisions
    always_comb begin
        credit_used = CSW'(q_cnt) + CSW'(inflight);
        imem_req    = !reset && !PCSrc && (credit_used < CSW'(DEPTH));
        fire        = imem_req && imem_ready;
        // a response with nothing in flight is a protocol error and is ignored
        resp        = imem_rvalid && (inflight != '0);
        push        = resp && (drop_cnt == '0) && !PCSrc;
        pop         = (q_cnt != '0) && !stall && !PCSrc;
    end

    assign imem_addr   = fetch_pc;
    assign instr_valid = (q_cnt != '0);
    assign Instr       = instr_valid ? q_data[q_head] : '0;
    assign instr_pc    = instr_valid ? q_pc[q_head]   : '0;

    // control state: fetch PC, pointers and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            q_head   <= '0;
            q_tail   <= '0;
            q_cnt    <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            if (fire) r_tail <= r_tail + PW'(1);
            if (resp) r_head <= r_head + PW'(1);
            inflight <= inflight + CW'(fire) - CW'(resp);

            if (PCSrc) begin
                // everything still in flight after this cycle belongs to the old path
                fetch_pc <= pc_target & ~ADDR_W'(3);
                drop_cnt <= inflight - CW'(resp);
                q_head   <= '0;
                q_tail   <= '0;
                q_cnt    <= '0;
            end else begin
                if (fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
                if (push) q_tail <= q_tail + PW'(1);
                if (pop)  q_head <= q_head + PW'(1);
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    // storage arrays; writes are gated by fire/push, which are low in reset
    always_ff @(posedge clk) begin
        if (fire) r_pc[r_tail] <= fetch_pc;
        if (push) begin
            q_data[q_tail] <= imem_rdata;
            q_pc[q_tail]   <= r_pc[r_head];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized phase for fetch_unit.
// The reference tracks requests as an in-order list tagged with a redirect
// epoch; a response is delivered only if its epoch is current and it does not
// arrive in a redirect cycle. Delivered instructions form a FIFO model.
module tb_fetch_unit;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 26;
    localparam int unsigned DEPTH   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               PCSrc;
    logic [ADDR_W-1:0]  pc_target;
    logic               stall;
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .pc_target(pc_target), .stall(stall),
        .Instr(Instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] ins;
    } ent_t;

    req_t        mem_q[$];
    ent_t        exp_q[$];
    logic [31:0] seen[$];
    logic [31:0] exp_fetch;
    int unsigned epoch;
    int unsigned cyc;
    int unsigned lat;
    bit          rand_mode;
    int          errors;
    int          checks;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
        return h[INSTR_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one clock: drive at posedge+1, check at posedge+4, update model at next posedge
    task automatic cycle(input bit pcsrc, input logic [31:0] tgt, input bit stl, input bit rdy);
        logic        req_s, val_s;
        logic [31:0] pc_s, addr_s;
        req_t        r;
        ent_t        e;
        PCSrc      = pcsrc;
        pc_target  = tgt;
        stall      = stl;
        imem_ready = rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
            (!rand_mode || $urandom_range(0, 3) != 0)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = INSTR_W'($urandom);
        end
        #3;
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("Instr", 32'(Instr), 32'(exp_q[0].ins));
            chk("instr_pc", instr_pc, exp_q[0].pc);
        end else begin
            chk("Instr_idle", 32'(Instr), 32'h0);
            chk("instr_pc_idle", instr_pc, 32'h0);
        end
        chk("imem_req", 32'(imem_req), 32'(!pcsrc && (exp_q.size() + mem_q.size() < DEPTH)));
        chk("imem_addr", imem_addr, exp_fetch);
        req_s  = imem_req;
        val_s  = instr_valid;
        pc_s   = instr_pc;
        addr_s = imem_addr;
        @(posedge clk);
        if (val_s && !stl && !pcsrc) seen.push_back(pc_s);
        if (exp_q.size() != 0 && !stl && !pcsrc) void'(exp_q.pop_front());
        if (imem_rvalid) begin
            r = mem_q.pop_front();
            if (r.epoch == epoch && !pcsrc) begin
                e.pc  = r.addr;
                e.ins = instr_of(r.addr);
                exp_q.push_back(e);
            end
        end
        if (req_s && rdy) begin
            r.addr  = addr_s;
            r.epoch = epoch;
            r.due   = cyc + (rand_mode ? $urandom_range(1, 4) : lat);
            mem_q.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (pcsrc) begin
            epoch++;
            exp_q.delete();
            exp_fetch = tgt & ~32'h3;
        end
        cyc++;
        #1;
    endtask

    // asynchronous reset asserted between edges; memory resets with the core
    task automatic do_reset();
        #2;
        reset       = 1'b1;
        PCSrc       = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        stall       = 1'b0;
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_Instr", 32'(Instr), 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        mem_q.delete();
        exp_q.delete();
        seen.delete();
        exp_fetch = 32'h0;
        epoch++;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; PCSrc = 1'b0; pc_target = '0; stall = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        errors = 0; checks = 0; epoch = 0; cyc = 0; lat = 1; rand_mode = 1'b0;
        exp_fetch = 32'h0;

        // 1: streaming with latency 1; first instruction two cycles after first request
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            if (i < 3) chk("t1_latency", 32'(instr_valid), 32'(i >= 1));
        end
        chk("t1_count", 32'(seen.size() >= 3), 32'h1);
        chk("t1_pc0", seen[0], 32'h0);
        chk("t1_pc1", seen[1], 32'h4);
        chk("t1_pc2", seen[2], 32'h8);

        // 2: held stall stops issue at DEPTH and keeps the head stable
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            chk("t2_head_pc", instr_pc, 32'h0);
            chk("t2_head_instr", 32'(Instr), 32'(instr_of(32'h0)));
            chk("t2_no_req", 32'(imem_req), 32'h0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_count", 32'(seen.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) chk("t2_drain", seen[i], 32'(4 * i));

        // 3: redirect with two requests in flight at latency 3
        do_reset();
        lat = 3;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h100, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_count", 32'(seen.size() >= 2), 32'h1);
        chk("t3_pc0", seen[0], 32'h100);
        chk("t3_pc1", seen[1], 32'h104);

        // 4: redirect coinciding with a response and a pop, then a second redirect
        do_reset();
        lat = 1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        seen.delete();
        cycle(1'b1, 32'h300, 1'b0, 1'b1);
        chk("t4_flushed", 32'(instr_valid), 32'h0);
        cycle(1'b1, 32'h200, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_count", 32'(seen.size() >= 2), 32'h1);
        chk("t4_pc0", seen[0], 32'h200);
        chk("t4_pc1", seen[1], 32'h204);

        // 5: fetch address wraps past the top of the address space
        do_reset();
        cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_count", 32'(seen.size() >= 3), 32'h1);
        chk("t5_pc0", seen[0], 32'hFFFF_FFF8);
        chk("t5_pc1", seen[1], 32'hFFFF_FFFC);
        chk("t5_pc2", seen[2], 32'h0000_0000);

        // 6: asynchronous reset with a full queue, then restart at RESET_PC
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_full", 32'(instr_valid), 32'h1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_restart", seen[0], 32'h0);

        // randomized traffic: ready, stall, latency, response gaps, redirects
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
